// File: rtl/mem_ctrl_pkg.sv
// Shared codes and helpers for the MEM-stage memory controller.
// Optional build macro: MEMCTRL_IO_WAIT_EN (IO back-pressure on writes).
package mem_ctrl_pkg;

   localparam int         MEM_RAM_ADDR_LEN = 17;
   localparam logic [1:0] IO_REGION        = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mem_status_e;

   typedef enum logic [2:0] {
      RW_NONE  = 3'b000,
      RW_READ  = 3'b001,
      RW_WRITE = 3'b010
   } rw_code_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_READ  = 2'b01,
      S_WRITE = 2'b10,
      S_DONE  = 2'b11
   } fsm_state_e;

   function automatic logic [2:0] qty_to_n(input logic [3:0] quantity);
      case (quantity)
         4'd1:    qty_to_n = 3'd1;
         4'd2:    qty_to_n = 3'd2;
         default: qty_to_n = 3'd4;
      endcase
   endfunction

   function automatic logic io_blocked(input logic [1:0] region, input logic full);
      io_blocked = (region == IO_REGION) && full;
   endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// 4x8 byte register file: bulk load, single-byte write by index, clear, byte read.
module mem_byte_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        ld,
   input  logic [31:0] ld_word,
   input  logic        wr,
   input  logic [1:0]  wr_idx,
   input  logic [7:0]  wr_byte,
   input  logic [1:0]  rd_idx,
   output logic [7:0]  rd_byte,
   output logic [31:0] word
);

   logic [7:0] bytes_r [4];

   // Byte storage; clear has priority over load, load over single-byte write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) bytes_r[i] <= 8'h00;
      end else if (clr) begin
         for (int i = 0; i < 4; i++) bytes_r[i] <= 8'h00;
      end else if (ld) begin
         for (int i = 0; i < 4; i++) bytes_r[i] <= ld_word[8*i +: 8];
      end else if (wr) begin
         bytes_r[wr_idx] <= wr_byte;
      end
   end

   assign rd_byte = bytes_r[rd_idx];
   assign word    = {bytes_r[3], bytes_r[2], bytes_r[1], bytes_r[0]};

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage memory controller: serialises 1/2/4-byte requests onto an 8-bit RAM bus.
// Optional build macro: MEMCTRL_IO_WAIT_EN (stall IO-region writes while io_buffer_full).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_LEN     = 32,
   parameter int RAM_ADDR_LEN = MEM_RAM_ADDR_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_LEN-1:0]     addr_to_mem,
   input  logic [ADDR_LEN-1:0]     data_to_mem,
   input  logic [2:0]              rw_mem,
   input  logic [3:0]              quantity,
   output logic [ADDR_LEN-1:0]     data_from_mem,
   output logic [1:0]              mem_status,
   input  logic [7:0]              ram_din,
   output logic [7:0]              ram_dout,
   output logic [RAM_ADDR_LEN-1:0] ram_a,
   output logic                    ram_wr,
   input  logic                    io_buffer_full
);

   fsm_state_e              state_r;
   mem_status_e             mem_status_r;
   logic [ADDR_LEN-1:0]     addr_r;
   logic [2:0]              n_r;
   logic [2:0]              cnt_r;
   logic [ADDR_LEN-1:0]     data_from_mem_r;
   logic [RAM_ADDR_LEN-1:0] ram_a_r;
   logic [7:0]              ram_dout_r;
   logic                    ram_wr_r;

   logic                    asm_clr_s;
   logic                    asm_ld_s;
   logic                    asm_wr_s;
   logic [1:0]              asm_wr_idx_s;
   logic [1:0]              asm_rd_idx_s;
   logic [7:0]              asm_rd_byte_s;
   logic [31:0]             asm_word_s;
   logic [31:0]             rd_word_s;
   logic [ADDR_LEN-1:0]     cur_addr_s;
   logic [ADDR_LEN-1:0]     next_addr_s;
   logic                    wr_step_s;
   logic                    acc_wr_en_s;
   logic                    cur_wr_en_s;
   logic                    next_wr_en_s;
   logic                    unused_s;

   assign cur_addr_s   = addr_r + ADDR_LEN'(cnt_r);
   assign next_addr_s  = cur_addr_s + ADDR_LEN'(1'b1);
   assign asm_wr_idx_s = cnt_r[1:0] - 2'd1;
   assign asm_rd_idx_s = cnt_r[1:0] + 2'd1;
   assign unused_s     = ^{io_buffer_full, cur_addr_s, next_addr_s[ADDR_LEN-1:RAM_ADDR_LEN]};

   mem_byte_assembler u_asm (
      .clk     (clk),
      .rst     (rst),
      .clr     (asm_clr_s),
      .ld      (asm_ld_s),
      .ld_word (data_to_mem[31:0]),
      .wr      (asm_wr_s),
      .wr_idx  (asm_wr_idx_s),
      .wr_byte (ram_din),
      .rd_idx  (asm_rd_idx_s),
      .rd_byte (asm_rd_byte_s),
      .word    (asm_word_s)
   );

   // Buffer control: clear on read accept, bulk load on write accept, fill while reading
   always_comb begin
      asm_clr_s = 1'b0;
      asm_ld_s  = 1'b0;
      asm_wr_s  = 1'b0;
      if (state_r == S_IDLE) begin
         asm_clr_s = (rw_mem == RW_READ);
         asm_ld_s  = (rw_mem == RW_WRITE);
      end else if (state_r == S_READ) begin
         asm_wr_s = (cnt_r != 3'd0);
      end else begin
         asm_wr_s = 1'b0;
      end
   end

   // Final read word: the last byte arrives on the same edge that loads data_from_mem
   always_comb begin
      rd_word_s = asm_word_s;
      rd_word_s[{asm_wr_idx_s, 3'b000} +: 8] = ram_din;
   end

   // Write strobe decisions; a held (unstrobed) cycle does not advance the byte counter
   always_comb begin
`ifdef MEMCTRL_IO_WAIT_EN
      wr_step_s    = ram_wr_r;
      acc_wr_en_s  = ~io_blocked(addr_to_mem[17:16], io_buffer_full);
      cur_wr_en_s  = ~io_blocked(cur_addr_s[17:16], io_buffer_full);
      next_wr_en_s = ~io_blocked(next_addr_s[17:16], io_buffer_full);
`else
      wr_step_s    = 1'b1;
      acc_wr_en_s  = 1'b1;
      cur_wr_en_s  = 1'b1;
      next_wr_en_s = 1'b1;
`endif
   end

   // Transfer sequencing with registered status and RAM bus outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= S_IDLE;
         mem_status_r    <= ST_IDLE;
         addr_r          <= '0;
         n_r             <= 3'd0;
         cnt_r           <= 3'd0;
         data_from_mem_r <= '0;
         ram_a_r         <= '0;
         ram_dout_r      <= 8'h00;
         ram_wr_r        <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               cnt_r    <= 3'd0;
               ram_wr_r <= 1'b0;
               if (rw_mem == RW_READ) begin
                  addr_r       <= addr_to_mem;
                  n_r          <= qty_to_n(quantity);
                  ram_a_r      <= addr_to_mem[RAM_ADDR_LEN-1:0];
                  mem_status_r <= ST_BUSY;
                  state_r      <= S_READ;
               end else if (rw_mem == RW_WRITE) begin
                  addr_r       <= addr_to_mem;
                  n_r          <= qty_to_n(quantity);
                  ram_a_r      <= addr_to_mem[RAM_ADDR_LEN-1:0];
                  ram_dout_r   <= data_to_mem[7:0];
                  ram_wr_r     <= acc_wr_en_s;
                  mem_status_r <= ST_BUSY;
                  state_r      <= S_WRITE;
               end else begin
                  mem_status_r <= ST_IDLE;
               end
            end
            S_READ: begin
               if (cnt_r == n_r) begin
                  data_from_mem_r <= ADDR_LEN'(rd_word_s);
                  mem_status_r    <= ST_DONE;
                  state_r         <= S_DONE;
               end else begin
                  cnt_r <= cnt_r + 3'd1;
                  if ((cnt_r + 3'd1) < n_r) begin
                     ram_a_r <= next_addr_s[RAM_ADDR_LEN-1:0];
                  end
               end
            end
            S_WRITE: begin
               if (!wr_step_s) begin
                  ram_wr_r <= cur_wr_en_s;
               end else if (cnt_r == (n_r - 3'd1)) begin
                  ram_wr_r     <= 1'b0;
                  mem_status_r <= ST_DONE;
                  state_r      <= S_DONE;
               end else begin
                  cnt_r      <= cnt_r + 3'd1;
                  ram_a_r    <= next_addr_s[RAM_ADDR_LEN-1:0];
                  ram_dout_r <= asm_rd_byte_s;
                  ram_wr_r   <= next_wr_en_s;
               end
            end
            S_DONE: begin
               ram_wr_r     <= 1'b0;
               mem_status_r <= ST_IDLE;
               state_r      <= S_IDLE;
            end
            default: begin
               ram_wr_r     <= 1'b0;
               mem_status_r <= ST_IDLE;
               state_r      <= S_IDLE;
            end
         endcase
      end
   end

   assign data_from_mem = data_from_mem_r;
   assign mem_status    = mem_status_r;
   assign ram_a         = ram_a_r;
   assign ram_dout      = ram_dout_r;
   assign ram_wr        = ram_wr_r;

endmodule
